test_hps_system_led_sequencer: RTL and testbench

Autonomous LED pattern sequencer that owns the write side of the 10-bit LED PIO slave (`pio_LED`, s1). The HPS configures a pattern, mode and step period through a small Avalon-MM slave. The block then issues single-cycle Avalon writes to PIO register 0 to produce static, blinking or chasing LED output without CPU involvement. It sits in the FPGA fabric between the HPS lightweight bridge and the PIO.

---
 rtl/test_hps_system_led_sequencer.sv | 154 +++++++++++++++
 tb/tb_test_hps_system_led_sequencer.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/test_hps_system_led_sequencer.sv
// Autonomous LED pattern sequencer driving the write side of a 10-bit LED PIO.
// Define LED_SEQ_CHASE_EN to enable chase mode (MODE=2); otherwise MODE=2 acts as static.
module test_hps_system_led_sequencer #(
   parameter int unsigned LED_W    = 10,
   parameter int unsigned PERIOD_W = 24
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [1:0]  s_address,
   input  logic        s_chipselect,
   input  logic        s_write_n,
   input  logic [31:0] s_writedata,
   output logic [31:0] s_readdata,
   output logic [1:0]  m_address,
   output logic        m_chipselect,
   output logic        m_write_n,
   output logic [31:0] m_writedata
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_START = 2'd1;
   localparam logic [1:0] S_RUN   = 2'd2;
   localparam logic [1:0] S_STOP  = 2'd3;

   logic [1:0]          state;
   logic                ctrl_en;
   logic [1:0]          ctrl_mode;
   logic [LED_W-1:0]    pattern;
   logic [PERIOD_W-1:0] period;
   logic [PERIOD_W-1:0] counter;
   logic [LED_W-1:0]    frame;
   logic                strobe;

   logic                cfg_wr;
   logic                ctrl_on;
   logic                ctrl_off;
   logic                restart;
   logic                step_en;
   logic [LED_W-1:0]    step_frame;
   logic                unused_wdata;

   assign unused_wdata = &{1'b0, s_writedata};

   always_comb begin
      cfg_wr   = s_chipselect & ~s_write_n;
      ctrl_on  = cfg_wr && (s_address == 2'd0) && s_writedata[0];
      ctrl_off = cfg_wr && (s_address == 2'd0) && !s_writedata[0];
      restart  = ctrl_on || (cfg_wr && ((s_address == 2'd1) || (s_address == 2'd2)));
   end

   // Blink toggles between PATTERN and zero; frame is always one of the two while running.
   always_comb begin
      step_en    = 1'b0;
      step_frame = frame;
      case (ctrl_mode)
         2'd1: begin
            step_en    = 1'b1;
            step_frame = (frame == '0) ? pattern : '0;
         end
`ifdef LED_SEQ_CHASE_EN
         2'd2: begin
            step_en    = 1'b1;
            step_frame = {frame[LED_W-2:0], frame[LED_W-1]};
         end
`endif
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ctrl_en   <= 1'b0;
         ctrl_mode <= '0;
         pattern   <= '0;
         period    <= '0;
      end else if (cfg_wr) begin
         case (s_address)
            2'd0: begin
               ctrl_en   <= s_writedata[0];
               ctrl_mode <= s_writedata[2:1];
            end
            2'd1: pattern <= s_writedata[LED_W-1:0];
            2'd2: period  <= s_writedata[PERIOD_W-1:0];
            default: ;
         endcase
      end
   end

   // Config writes take priority over the terminal-count step in every active state.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state   <= S_IDLE;
         counter <= '0;
         frame   <= '0;
         strobe  <= 1'b0;
      end else begin
         strobe <= 1'b0;
         case (state)
            S_IDLE: begin
               counter <= '0;
               if (ctrl_on) state <= S_START;
            end
            S_START: begin
               frame   <= pattern;
               counter <= '0;
               strobe  <= 1'b1;
               if (ctrl_off)     state <= S_STOP;
               else if (restart) state <= S_START;
               else              state <= S_RUN;
            end
            S_RUN: begin
               if (ctrl_off) begin
                  state <= S_STOP;
               end else if (restart) begin
                  state <= S_START;
               end else if (counter == period) begin
                  counter <= '0;
                  if (step_en) begin
                     frame  <= step_frame;
                     strobe <= 1'b1;
                  end
               end else begin
                  counter <= counter + 1'b1;
               end
            end
            default: begin
               frame   <= '0;
               counter <= '0;
               strobe  <= 1'b1;
               state   <= ctrl_on ? S_START : S_IDLE;
            end
         endcase
      end
   end

   always_comb begin
      s_readdata = '0;
      case (s_address)
         2'd0: s_readdata[2:0] = {ctrl_mode, ctrl_en};
         2'd1: s_readdata[LED_W-1:0] = pattern;
         2'd2: s_readdata[PERIOD_W-1:0] = period;
         default: begin
            s_readdata[0]         = (state != S_IDLE);
            s_readdata[LED_W+3:4] = frame;
         end
      endcase
   end

   assign m_address    = 2'b00;
   assign m_chipselect = strobe;
   assign m_write_n    = ~strobe;
   assign m_writedata  = {{(32-LED_W){1'b0}}, frame};

endmodule

// File: tb/tb_test_hps_system_led_sequencer.sv
// Directed bench for the LED sequencer: records every PIO strobe with its cycle
// stamp and compares against hand-computed data/timing for each scenario.
module tb_test_hps_system_led_sequencer;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [1:0]  s_address;
   logic        s_chipselect;
   logic        s_write_n;
   logic [31:0] s_writedata;
   logic [31:0] s_readdata;
   logic [1:0]  m_address;
   logic        m_chipselect;
   logic        m_write_n;
   logic [31:0] m_writedata;

   test_hps_system_led_sequencer #(.LED_W(10), .PERIOD_W(24)) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .s_address    (s_address),
      .s_chipselect (s_chipselect),
      .s_write_n    (s_write_n),
      .s_writedata  (s_writedata),
      .s_readdata   (s_readdata),
      .m_address    (m_address),
      .m_chipselect (m_chipselect),
      .m_write_n    (m_write_n),
      .m_writedata  (m_writedata)
   );

   always #5 clk = ~clk;

   int          n_cmp = 0;
   int          n_err = 0;
   int          cyc = 0;
   int          bad_proto = 0;
   logic [31:0] sdata[$];
   int          scyc[$];

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if ((m_chipselect !== ~m_write_n) || (m_address !== 2'b00)) bad_proto++;
      if (m_chipselect === 1'b1 && m_write_n === 1'b0) begin
         sdata.push_back(m_writedata);
         scyc.push_back(cyc);
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Presents one write for a single cycle; returns at the negedge after acceptance.
   task automatic cfg_write(input logic [1:0] addr, input logic [31:0] data, output int acc);
      @(negedge clk);
      s_address    = addr;
      s_writedata  = data;
      s_chipselect = 1'b1;
      s_write_n    = 1'b0;
      @(negedge clk);
      s_chipselect = 1'b0;
      s_write_n    = 1'b1;
      acc          = cyc;
   endtask

   task automatic rd(input logic [1:0] addr, output logic [31:0] data);
      s_address = addr;
      #1;
      data = s_readdata;
   endtask

   function automatic int first_after(input int c);
      for (int i = 0; i < scyc.size(); i++)
         if (scyc[i] > c) return i;
      return scyc.size();
   endfunction

   initial begin
      int          tw;
      int          tmp;
      int          b;
      int          n0;
      logic [31:0] r;
      logic [31:0] exp_chase[4];
      int          exp_count;

      reset_n      = 1'b0;
      s_address    = 2'd0;
      s_chipselect = 1'b0;
      s_write_n    = 1'b1;
      s_writedata  = '0;
      idle(3);
      check("rst_cs", {31'b0, m_chipselect}, 32'd0);
      check("rst_wn", {31'b0, m_write_n}, 32'd1);
      check("rst_addr", {30'b0, m_address}, 32'd0);
      check("rst_wd", m_writedata, 32'd0);
      for (int a = 0; a < 4; a++) begin
         rd(2'(a), r);
         check("rst_rd", r, 32'd0);
      end
      @(negedge clk);
      reset_n = 1'b1;
      idle(2);

      // Static: one strobe one cycle after CTRL, then silence.
      cfg_write(2'd1, 32'h155, tmp);
      check("idle_pat_nostrobe", sdata.size(), 0);
      cfg_write(2'd0, 32'h1, tw);
      idle(100);
      b = first_after(tw);
      check("static_count", sdata.size() - b, 1);
      check("static_data", sdata[b], 32'h155);
      check("static_cyc", scyc[b], tw + 1);
      rd(2'd0, r); check("rd_ctrl", r, 32'h1);
      rd(2'd1, r); check("rd_pat", r, 32'h155);
      rd(2'd3, r); check("rd_status_static", r, 32'h1551);

      // Blink, PERIOD=3.
      cfg_write(2'd1, 32'h3FF, tmp);
      cfg_write(2'd2, 32'h3, tmp);
      idle(3);
      cfg_write(2'd0, 32'h3, tw);
      idle(14);
      b = first_after(tw);
      check("blink_count", sdata.size() - b, 4);
      for (int k = 0; k < 4; k++) begin
         check("blink_data", sdata[b+k], (k % 2 == 0) ? 32'h3FF : 32'h0);
         check("blink_cyc", scyc[b+k], tw + 1 + 4 * k);
      end

      // Disable mid-blink: a single STOP strobe of zero, then idle.
      cfg_write(2'd0, 32'h0, tw);
      idle(12);
      b = first_after(tw);
      check("stop_count", sdata.size() - b, 1);
      check("stop_data", sdata[b], 32'h0);
      check("stop_cyc", scyc[b], tw + 1);
      rd(2'd3, r); check("stop_status", r, 32'h0);

      // PATTERN write coinciding with terminal count suppresses the step.
      cfg_write(2'd1, 32'h0F0, tmp);
      cfg_write(2'd0, 32'h3, tw);
      idle(3);
      cfg_write(2'd1, 32'h00F, tmp);
      check("tc_write_cyc", tmp, tw + 5);
      idle(3);
      b = first_after(tw);
      check("tc_count", sdata.size() - b, 2);
      check("tc_start_data", sdata[b], 32'h0F0);
      check("tc_new_data", sdata[b+1], 32'h00F);
      check("tc_new_cyc", scyc[b+1], tw + 6);

      // Chase, PERIOD=0 (static when chase is compiled out).
`ifdef LED_SEQ_CHASE_EN
      exp_chase = '{32'h201, 32'h003, 32'h006, 32'h00C};
      exp_count = 4;
`else
      exp_chase = '{32'h201, 32'h201, 32'h201, 32'h201};
      exp_count = 1;
`endif
      cfg_write(2'd2, 32'h0, tmp);
      cfg_write(2'd1, 32'h201, tmp);
      cfg_write(2'd0, 32'h5, tw);
      idle(2);
      rd(2'd3, r); check("chase_status1", r, {exp_chase[1][27:0], 4'h1});
      idle(1);
      rd(2'd3, r); check("chase_status2", r, {exp_chase[2][27:0], 4'h1});
      idle(1);
      b = first_after(tw);
      check("chase_count", sdata.size() - b, exp_count);
      for (int k = 0; k < exp_count; k++) begin
         check("chase_data", sdata[b+k], exp_chase[k]);
         check("chase_cyc", scyc[b+k], tw + 1 + k);
      end

      // Asynchronous reset mid-blink.
      cfg_write(2'd0, 32'h3, tw);
      idle(3);
      reset_n = 1'b0;
      #1;
      check("arst_cs", {31'b0, m_chipselect}, 32'd0);
      check("arst_wn", {31'b0, m_write_n}, 32'd1);
      check("arst_wd", m_writedata, 32'd0);
      rd(2'd3, r); check("arst_status", r, 32'h0);
      rd(2'd0, r); check("arst_ctrl", r, 32'h0);
      rd(2'd2, r); check("arst_period", r, 32'h0);
      n0 = sdata.size();
      idle(2);
      reset_n = 1'b1;
      idle(5);
      check("post_rst_nostrobe", sdata.size(), n0);
      check("protocol", bad_proto, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
